// File: rtl/chan_pkg.sv
// rtl/chan_pkg.sv - shared types and LFSR constants for the channel error injector
package chan_pkg;

  typedef enum logic [1:0] {CH_PASS, CH_BURST, CH_RAND, CH_RSVD} chan_mode_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  // One Galois step: shift right, fold the taps back in when a one falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/chan_lfsr16.sv
// rtl/chan_lfsr16.sv - 16-bit Galois LFSR with load and advance controls
module chan_lfsr16
  import chan_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // A load with adv set means the seed was consumed this cycle, so step past it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (load) begin
      state <= adv ? lfsr_step(seed) : seed;
    end else if (adv) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/channel_error_injector.sv
// rtl/channel_error_injector.sv - channel model that corrupts encoded symbols and counts errors
module channel_error_injector
  import chan_pkg::*;
#(
  parameter int          CNT_W     = 8,
  parameter int          STAT_W    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  period_len,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [1:0]        bit_sel,
  input  logic [7:0]        rand_thresh,
  input  logic              valid_i,
  input  logic [1:0]        d_in,
  output logic              valid_o,
  output logic [1:0]        d_out,
  output logic [1:0]        err_o,
  output logic [STAT_W-1:0] bad_bit_ct,
  output logic [STAT_W-1:0] word_ct
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? LFSR_DEFAULT : LFSR_SEED;

  chan_mode_t       sh_mode;
  logic [CNT_W-1:0] sh_period, sh_burst, pos;
  logic [1:0]       sh_sel;
  logic [7:0]       sh_thresh;
  logic [15:0]      lfsr_state;

  // A cfg_load word is processed with the incoming config, pos=0 and the seed.
  chan_mode_t       eff_mode;
  logic [CNT_W-1:0] eff_period, eff_burst, eff_pos, pos_next;
  logic [1:0]       eff_sel, mask;
  logic [7:0]       eff_thresh;
  logic [15:0]      eff_lfsr;
  logic             hit, burst_active;

  assign eff_mode   = cfg_load ? chan_mode_t'(mode) : sh_mode;
  assign eff_period = cfg_load ? period_len  : sh_period;
  assign eff_burst  = cfg_load ? burst_len   : sh_burst;
  assign eff_sel    = cfg_load ? bit_sel     : sh_sel;
  assign eff_thresh = cfg_load ? rand_thresh : sh_thresh;
  assign eff_pos    = cfg_load ? '0          : pos;
  // All-zero is the Galois lock-up state; treat it as a reload rather than stalling.
  assign eff_lfsr   = (cfg_load || lfsr_state == 16'h0) ? SEED : lfsr_state;

  assign burst_active = (eff_mode == CH_BURST) && (eff_period != '0);
  assign pos_next     = (eff_pos == eff_period - CNT_W'(1)) ? '0 : eff_pos + CNT_W'(1);

  always_comb begin
    hit = 1'b0;
    if (eff_period != '0) begin
      case (eff_mode)
        CH_BURST: hit = (eff_burst >= eff_period) || (eff_pos >= eff_period - eff_burst);
        CH_RAND:  hit = eff_lfsr[7:0] < eff_thresh;
        default:  hit = 1'b0;
      endcase
    end
    mask = hit ? eff_sel : 2'b00;
  end

  chan_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (cfg_load || lfsr_state == 16'h0),
    .adv   (valid_i && eff_mode == CH_RAND),
    .seed  (SEED),
    .state (lfsr_state)
  );

  // Saturating statistics; cfg_load restarts them from zero.
  logic [STAT_W-1:0] base_bad, base_word, bad_next, word_next;
  logic [STAT_W:0]   bad_sum, word_sum;

  assign base_bad  = cfg_load ? '0 : bad_bit_ct;
  assign base_word = cfg_load ? '0 : word_ct;
  assign bad_sum   = {1'b0, base_bad} + (STAT_W+1)'(mask[0]) + (STAT_W+1)'(mask[1]);
  assign word_sum  = {1'b0, base_word} + (STAT_W+1)'(1);
  assign bad_next  = bad_sum[STAT_W]  ? '1 : bad_sum[STAT_W-1:0];
  assign word_next = word_sum[STAT_W] ? '1 : word_sum[STAT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode    <= CH_PASS;
      sh_period  <= '0;
      sh_burst   <= '0;
      sh_sel     <= '0;
      sh_thresh  <= '0;
      pos        <= '0;
      valid_o    <= 1'b0;
      d_out      <= '0;
      err_o      <= '0;
      bad_bit_ct <= '0;
      word_ct    <= '0;
    end else begin
      if (cfg_load) begin
        sh_mode   <= chan_mode_t'(mode);
        sh_period <= period_len;
        sh_burst  <= burst_len;
        sh_sel    <= bit_sel;
        sh_thresh <= rand_thresh;
      end
      valid_o    <= valid_i;
      err_o      <= valid_i ? mask : 2'b00;
      if (valid_i) begin
        d_out <= d_in ^ mask;
      end
      pos        <= (valid_i && burst_active) ? pos_next : eff_pos;
      bad_bit_ct <= valid_i ? bad_next  : base_bad;
      word_ct    <= valid_i ? word_next : base_word;
    end
  end

endmodule
